// File: rtl/bcd_counter_ndigit.sv
// ---------------------------------------------------------------------------
// bcd_counter_ndigit
//   Parametrised multi-digit BCD up/down counter with parallel load,
//   wrap/saturate behaviour at the limits, optional rising-edge detection
//   of the up/down requests and one-cycle carry/borrow pulses.
//
// Parameters
//   DIGITS      number of BCD digits (1..8)
//   SATURATE    0 = wrap at the limits, 1 = hold at the limits
//   EDGE_DETECT 1 = one count per rising edge of up/down (sampled on en)
//               0 = one count per enabled cycle while the level is high
//
// Ports
//   i_clk       system clock, rising edge
//   i_reset     synchronous active-high reset
//   i_en        count enable tick
//   i_up        count-up request
//   i_down      count-down request
//   i_load      parallel load strobe (acts regardless of i_en)
//   i_load_val  packed BCD load value, digit 0 in bits [3:0]
//   o_bcd       packed BCD count, digit 0 in bits [3:0]
//   o_carry     one-cycle pulse on an up-count at maximum
//   o_borrow    one-cycle pulse on a down-count at zero
//   o_at_max    every digit equals 9
//   o_at_min    every digit equals 0
// ---------------------------------------------------------------------------
module bcd_counter_ndigit #(
  parameter int DIGITS      = 2,
  parameter int SATURATE    = 0,
  parameter int EDGE_DETECT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic                  i_up,
  input  logic                  i_down,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_val,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_carry,
  output logic                  o_borrow,
  output logic                  o_at_max,
  output logic                  o_at_min
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] r_bcd;
  logic         r_carry;
  logic         r_borrow;
  logic         r_up_prev;
  logic         r_down_prev;

  logic         w_up_evt;
  logic         w_down_evt;
  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;
  logic [W-1:0] w_clamped;
  logic         w_at_max;
  logic         w_at_min;

  // Ripple increment: a digit steps only when every lower digit is 9.
  // All 9s naturally rolls over to all 0s.
  function automatic logic [W-1:0] f_bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         ripple;
    logic [3:0]   d;
    res    = v;
    ripple = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (ripple) begin
        if (d == 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = d + 4'd1;
        end
      end else begin
        res[4*i +: 4] = d;
      end
      ripple = ripple & (d == 4'd9);
    end
    return res;
  endfunction

  // Ripple decrement: a digit steps only when every lower digit is 0.
  // All 0s naturally rolls under to all 9s.
  function automatic logic [W-1:0] f_bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         ripple;
    logic [3:0]   d;
    res    = v;
    ripple = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (ripple) begin
        if (d == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = d - 4'd1;
        end
      end else begin
        res[4*i +: 4] = d;
      end
      ripple = ripple & (d == 4'd0);
    end
    return res;
  endfunction

  // Non-BCD load digits (A..F) are forced to 9 so the count stays legal.
  function automatic logic [W-1:0] f_bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic [3:0]   d;
    res = v;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (d > 4'd9) begin
        res[4*i +: 4] = 4'd9;
      end else begin
        res[4*i +: 4] = d;
      end
    end
    return res;
  endfunction

  // True when every digit of v equals the given digit value.
  function automatic logic f_all_digits(input logic [W-1:0] v, input logic [3:0] dv);
    logic eq;
    eq = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      eq = eq & (v[4*i +: 4] == dv);
    end
    return eq;
  endfunction

  // Next-value candidates and limit decodes of the registered count.
  always_comb begin
    w_inc     = f_bcd_inc(r_bcd);
    w_dec     = f_bcd_dec(r_bcd);
    w_clamped = f_bcd_clamp(i_load_val);
    w_at_max  = f_all_digits(r_bcd, 4'd9);
    w_at_min  = f_all_digits(r_bcd, 4'd0);
  end

  // Count events exist only on en cycles; edge mode compares against history.
  always_comb begin
    w_up_evt   = 1'b0;
    w_down_evt = 1'b0;
    if (i_en) begin
      if (EDGE_DETECT != 0) begin
        w_up_evt   = i_up & ~r_up_prev;
        w_down_evt = i_down & ~r_down_prev;
      end else begin
        w_up_evt   = i_up;
        w_down_evt = i_down;
      end
    end else begin
      w_up_evt   = 1'b0;
      w_down_evt = 1'b0;
    end
  end

  // Counter state, history and pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bcd       <= {W{1'b0}};
      r_carry     <= 1'b0;
      r_borrow    <= 1'b0;
      r_up_prev   <= 1'b0;
      r_down_prev <= 1'b0;
    end else begin
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      // History follows the inputs only on en ticks, even during a load.
      if (i_en) begin
        r_up_prev   <= i_up;
        r_down_prev <= i_down;
      end else begin
        r_up_prev   <= r_up_prev;
        r_down_prev <= r_down_prev;
      end
      if (i_load) begin
        r_bcd <= w_clamped;
      end else if (w_up_evt && w_down_evt) begin
        // Conflicting requests cancel out.
        r_bcd <= r_bcd;
      end else if (w_up_evt) begin
        r_carry <= w_at_max;
        if (w_at_max && (SATURATE != 0)) begin
          r_bcd <= r_bcd;
        end else begin
          r_bcd <= w_inc;
        end
      end else if (w_down_evt) begin
        r_borrow <= w_at_min;
        if (w_at_min && (SATURATE != 0)) begin
          r_bcd <= r_bcd;
        end else begin
          r_bcd <= w_dec;
        end
      end else begin
        r_bcd <= r_bcd;
      end
    end
  end

  assign o_bcd    = r_bcd;
  assign o_carry  = r_carry;
  assign o_borrow = r_borrow;
  assign o_at_max = w_at_max;
  assign o_at_min = w_at_min;

endmodule
